trace_sched: RTL

// - Per-frame scheduler/arbiter for the trace buffer. Launches the tracer at the start of VBLANK,

---
 rtl/trace_sched_if.sv | 42 ++++
 rtl/trace_sched.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/trace_sched_if.sv
// Bundle between trace_sched and its neighbours (vga_sync, tracer, renderer, trace_buffer).
// debug_height exists only when TRACE_SCHED_DBG_FILL_EN is defined.
interface trace_sched_if #(
  parameter int ADDR_W = 10,
  parameter int H_W    = 8
);
  logic              vblank;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_col;
  logic              trc_start;
  logic              trc_req;
  logic [ADDR_W-1:0] trc_col;
  logic              trc_side;
  logic [H_W-1:0]    trc_height;
  logic              trc_ack;
  logic              trc_done;
  logic [ADDR_W-1:0] buf_col;
  logic              buf_we;
  logic [H_W:0]      buf_wdata;
  logic              frame_ok;
  logic              overrun;
  logic              col_err;
`ifdef TRACE_SCHED_DBG_FILL_EN
  logic [H_W-1:0]    debug_height;
`endif

  modport master (
`ifdef TRACE_SCHED_DBG_FILL_EN
    output debug_height,
`endif
    output vblank, rd_en, rd_col, trc_req, trc_col, trc_side, trc_height, trc_done,
    input  trc_start, trc_ack, buf_col, buf_we, buf_wdata, frame_ok, overrun, col_err
  );

  modport slave (
`ifdef TRACE_SCHED_DBG_FILL_EN
    input  debug_height,
`endif
    input  vblank, rd_en, rd_col, trc_req, trc_col, trc_side, trc_height, trc_done,
    output trc_start, trc_ack, buf_col, buf_we, buf_wdata, frame_ok, overrun, col_err
  );
endinterface

// File: rtl/trace_sched.sv
// Per-frame trace buffer scheduler: launches the tracer on VBLANK, arbitrates buffer access
// (renderer reads win), reports frame status. Optional debug fill: TRACE_SCHED_DBG_FILL_EN.
module trace_sched #(
  parameter int COLS   = 640,
  parameter int ADDR_W = 10,
  parameter int H_W    = 8
) (
  input  logic         clk,
  input  logic         reset,
  trace_sched_if.slave bus
);

  localparam logic [ADDR_W:0] C_COLS = (ADDR_W+1)'(COLS);
  localparam logic [ADDR_W:0] C_LAST = C_COLS - 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_TRACE,
    S_DONE,
    S_OVR
`ifdef TRACE_SCHED_DBG_FILL_EN
    , S_FILL
`endif
  } state_t;

  state_t          r_state;
  logic            r_vblank_q;
  logic            r_primed;
  logic            r_trc_start;
  logic            r_frame_ok;
  logic            r_overrun;
  logic            r_col_err;
  logic [ADDR_W:0] r_wcnt;

  logic              w_rise;
  logic              w_fall;
  logic              w_col_ok;
  logic              w_tracer_run;
  logic              w_trc_ack;
  logic              w_buf_we;
  logic [ADDR_W-1:0] w_buf_col;
  logic [H_W:0]      w_buf_wdata;
  logic              w_wcnt_inc;
  logic [ADDR_W:0]   w_wcnt_next;

  // The first cycle after reset only loads vblank_q, so a VBLANK already in progress
  // when reset releases is not mistaken for a fresh rise.
  assign w_rise   = bus.vblank & ~r_vblank_q & r_primed;
  assign w_fall   = ~bus.vblank & r_vblank_q;
  assign w_col_ok = ({1'b0, bus.trc_col} < C_COLS);

`ifdef TRACE_SCHED_DBG_FILL_EN
  assign w_tracer_run = (bus.debug_height == '0);
`else
  assign w_tracer_run = 1'b1;
`endif

  // NOTE: every output gets a default first, so no path through the block leaves a latch.
  always_comb begin
    w_trc_ack   = 1'b0;
    w_buf_we    = 1'b0;
    w_buf_col   = bus.trc_col;
    w_buf_wdata = {bus.trc_side, bus.trc_height};
    if (bus.rd_en) begin
      w_buf_col = bus.rd_col;
    end else if (r_state == S_TRACE) begin
      w_trc_ack = bus.trc_req;
      w_buf_we  = bus.trc_req & w_col_ok;
`ifdef TRACE_SCHED_DBG_FILL_EN
    end else if (r_state == S_FILL) begin
      w_buf_col   = r_wcnt[ADDR_W-1:0];
      w_buf_wdata = {1'b0, bus.debug_height};
      w_buf_we    = 1'b1;
`endif
    end
    if (!reset) begin
      w_trc_ack   = 1'b0;
      w_buf_we    = 1'b0;
      w_buf_col   = '0;
      w_buf_wdata = '0;
    end
  end

  assign w_wcnt_inc  = w_buf_we & (r_wcnt != C_COLS);
  assign w_wcnt_next = r_wcnt + {{ADDR_W{1'b0}}, w_wcnt_inc};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_vblank_q  <= 1'b0;
      r_primed    <= 1'b0;
      r_trc_start <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_overrun   <= 1'b0;
      r_col_err   <= 1'b0;
      r_wcnt      <= '0;
    end else begin
      r_vblank_q <= bus.vblank;
      r_primed   <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state     <= S_START;
            r_trc_start <= w_tracer_run;
          end
        end
        S_START: begin
          r_trc_start <= 1'b0;
          r_wcnt      <= '0;
          r_overrun   <= 1'b0;
          r_col_err   <= 1'b0;
`ifdef TRACE_SCHED_DBG_FILL_EN
          r_state     <= r_trc_start ? S_TRACE : S_FILL;
`else
          r_state     <= S_TRACE;
`endif
        end
        S_TRACE: begin
          r_wcnt <= w_wcnt_next;
          if (w_trc_ack && !w_col_ok) r_col_err <= 1'b1;
          // End of VBLANK wins over a simultaneous trc_done.
          if (w_fall) begin
            r_state    <= S_OVR;
            r_overrun  <= 1'b1;
            r_frame_ok <= 1'b0;
          end else if (bus.trc_done || r_wcnt == C_COLS) begin
            r_state    <= S_DONE;
            r_frame_ok <= (w_wcnt_next == C_COLS);
          end
        end
`ifdef TRACE_SCHED_DBG_FILL_EN
        S_FILL: begin
          r_wcnt <= w_wcnt_next;
          if (w_fall) begin
            r_state    <= S_OVR;
            r_overrun  <= 1'b1;
            r_frame_ok <= 1'b0;
          end else if (w_buf_we && r_wcnt == C_LAST) begin
            r_state    <= S_DONE;
            r_frame_ok <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          if (w_fall) r_state <= S_IDLE;
        end
        S_OVR: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.trc_start = r_trc_start;
  assign bus.trc_ack   = w_trc_ack;
  assign bus.buf_col   = w_buf_col;
  assign bus.buf_we    = w_buf_we;
  assign bus.buf_wdata = w_buf_wdata;
  assign bus.frame_ok  = r_frame_ok;
  assign bus.overrun   = r_overrun;
  assign bus.col_err   = r_col_err;

endmodule
